// File: rtl/fib_rx_port_arb.sv
// fib_rx_port_arb
//   Packet-granular round-robin scheduler that lets NUM_PORTS FMAC RX
//   sources share one bridge data FIFO (rf) and one byte-count FIFO (rcf).
//   For each packet it pops the ipcs/byte-count word from the granted port,
//   then pops that packet's data beats. The beats go into rf and the count
//   word goes into rcf. Zero-length packets are dropped and counted.
//
// Ports
//   clk_fib                fabric clock
//   reset                  asynchronous, active-high reset
//   fib_rx_mac_data_empty  per-port FMAC data FIFO empty
//   fib_rx_mac_pkt_data    per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fib_rx_mac_ipcs_empty  per-port ipcs FIFO empty
//   fib_rx_mac_ipcs_data   per-port ipcs word, port i at [i*BCNT_WIDTH +: BCNT_WIDTH]
//   fib_rx_mac_rd          data pop strobes (one-hot or zero)
//   fib_rx_mac_ipcs_rd     ipcs pop strobes (one-hot or zero)
//   wrusedw_rf             rf occupancy
//   wren_rf / datain_rf    rf write
//   wren_rcf / datain_rcf  rcf write (ipcs word verbatim)
//   rcf_port               port of the packet whose count is written
//   busy                   FSM not in IDLE
//   drop_cnt               saturating count of zero-length packets
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | wait for an eligible port and rf space, then grant + pop ipcs
// CNT_REQ  | ipcs read-latency cycle
// CNT_LAT  | latch ipcs word, drop if zero length, else load beat counter
// XFER     | pop data beats from the granted port, stall on empty
// DRAIN    | let the last beat reach rf, write rcf alongside it

module fib_rx_port_arb #(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 256,
  parameter int BCNT_WIDTH   = 64,
  parameter int DATA_PTR     = 10,
  parameter int SPACE_THRESH = 960
) (
  input  logic                             clk_fib,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             fib_rx_mac_data_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  fib_rx_mac_pkt_data,
  input  logic [NUM_PORTS-1:0]             fib_rx_mac_ipcs_empty,
  input  logic [NUM_PORTS*BCNT_WIDTH-1:0]  fib_rx_mac_ipcs_data,
  output logic [NUM_PORTS-1:0]             fib_rx_mac_rd,
  output logic [NUM_PORTS-1:0]             fib_rx_mac_ipcs_rd,
  input  logic [DATA_PTR:0]                wrusedw_rf,
  output logic                             wren_rf,
  output logic [DATA_WIDTH-1:0]            datain_rf,
  output logic                             wren_rcf,
  output logic [BCNT_WIDTH-1:0]            datain_rcf,
  output logic [1:0]                       rcf_port,
  output logic                             busy,
  output logic [15:0]                      drop_cnt
);

  localparam int UW = DATA_PTR + 1;
  localparam logic [UW-1:0] THRESH = UW'(SPACE_THRESH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_REQ = 3'd1,
    CNT_LAT = 3'd2,
    XFER    = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t                  state;
  logic [1:0]              grant;
  logic [1:0]              last_grant;
  logic [BCNT_WIDTH-1:0]   ipcs_word;
  logic [11:0]             remaining;
  logic                    drain_cnt;
  logic                    rd_d1;

  logic [NUM_PORTS-1:0]    eligible;
  logic                    start;
  logic                    arb_found;
  logic [1:0]              arb_port;
  logic [NUM_PORTS-1:0]    arb_onehot;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [BCNT_WIDTH-1:0]   sel_ipcs;
  logic                    sel_data_empty;
  logic [15:0]             len;
  logic [11:0]             beats;
  logic                    xfer_go;

  assign eligible = ~fib_rx_mac_ipcs_empty & ~fib_rx_mac_data_empty;
  assign start    = (|eligible) && (wrusedw_rf < THRESH);
  assign busy     = (state != IDLE);

  // Round robin: first eligible port after last_grant, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_port  = last_grant;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!arb_found && eligible[i] &&
            (((int'(last_grant) + k) % NUM_PORTS) == i)) begin
          arb_found = 1'b1;
          arb_port  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    arb_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      arb_onehot[i] = (arb_port == 2'(i));
    end
  end

  // Granted-port views of the per-port buses.
  always_comb begin
    sel_data       = '0;
    sel_ipcs       = '0;
    sel_data_empty = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == 2'(i)) begin
        sel_data       = fib_rx_mac_pkt_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ipcs       = fib_rx_mac_ipcs_data[i*BCNT_WIDTH +: BCNT_WIDTH];
        sel_data_empty = fib_rx_mac_data_empty[i];
      end
    end
  end

  assign len   = sel_ipcs[BCNT_WIDTH-1 -: 16];
  // 17-bit sum so a 0xFFFF length rounds up without wrapping.
  assign beats = 12'(({1'b0, len} + 17'd31) >> 5);

  // The data pop follows the current empty flag combinationally; a
  // registered strobe would see empty one cycle late and could pop a
  // FIFO that just ran dry.
  assign xfer_go = (state == XFER) && (remaining != 12'd0) && !sel_data_empty;

  always_comb begin
    fib_rx_mac_rd = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      fib_rx_mac_rd[i] = xfer_go && (grant == 2'(i));
    end
  end

  always_ff @(posedge clk_fib or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      grant              <= '0;
      last_grant         <= 2'(NUM_PORTS - 1);
      ipcs_word          <= '0;
      remaining          <= '0;
      drain_cnt          <= 1'b0;
      rd_d1              <= 1'b0;
      fib_rx_mac_ipcs_rd <= '0;
      wren_rf            <= 1'b0;
      datain_rf          <= '0;
      wren_rcf           <= 1'b0;
      datain_rcf         <= '0;
      rcf_port           <= '0;
      drop_cnt           <= '0;
    end else begin
      // Write stage: data is valid the cycle after the pop, registered once more.
      rd_d1 <= |fib_rx_mac_rd;
      if (rd_d1) begin
        wren_rf   <= 1'b1;
        datain_rf <= sel_data;
      end else begin
        wren_rf <= 1'b0;
      end

      wren_rcf           <= 1'b0;
      fib_rx_mac_ipcs_rd <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            grant              <= arb_port;
            last_grant         <= arb_port;
            fib_rx_mac_ipcs_rd <= arb_onehot;
            state              <= CNT_REQ;
          end
        end
        CNT_REQ: begin
          state <= CNT_LAT;
        end
        CNT_LAT: begin
          ipcs_word <= sel_ipcs;
          if (len == 16'd0) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            state <= IDLE;
          end else begin
            remaining <= beats;
            state     <= XFER;
          end
        end
        XFER: begin
          drain_cnt <= 1'b0;
          if (xfer_go) begin
            remaining <= remaining - 12'd1;
            if (remaining == 12'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          // First DRAIN cycle arms rcf so it lands with the last rf write.
          if (!drain_cnt) begin
            drain_cnt  <= 1'b1;
            wren_rcf   <= 1'b1;
            datain_rcf <= ipcs_word;
            rcf_port   <= grant;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_rx_port_arb.sv
module tb_fib_rx_port_arb;

  localparam int NP = 2;
  localparam int DW = 256;
  localparam int BW = 64;
  localparam int DP = 10;

  logic              clk_fib = 1'b0;
  logic              reset   = 1'b0;
  logic [NP-1:0]     data_empty = '1;
  logic [NP*DW-1:0]  pkt_data   = '0;
  logic [NP-1:0]     ipcs_empty = '1;
  logic [NP*BW-1:0]  ipcs_data  = '0;
  logic [NP-1:0]     fib_rx_mac_rd;
  logic [NP-1:0]     fib_rx_mac_ipcs_rd;
  logic [DP:0]       wrusedw_rf = '0;
  logic              wren_rf;
  logic [DW-1:0]     datain_rf;
  logic              wren_rcf;
  logic [BW-1:0]     datain_rcf;
  logic [1:0]        rcf_port;
  logic              busy;
  logic [15:0]       drop_cnt;

  fib_rx_port_arb #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .BCNT_WIDTH(BW), .DATA_PTR(DP), .SPACE_THRESH(960)
  ) dut (
    .clk_fib(clk_fib),
    .reset(reset),
    .fib_rx_mac_data_empty(data_empty),
    .fib_rx_mac_pkt_data(pkt_data),
    .fib_rx_mac_ipcs_empty(ipcs_empty),
    .fib_rx_mac_ipcs_data(ipcs_data),
    .fib_rx_mac_rd(fib_rx_mac_rd),
    .fib_rx_mac_ipcs_rd(fib_rx_mac_ipcs_rd),
    .wrusedw_rf(wrusedw_rf),
    .wren_rf(wren_rf),
    .datain_rf(datain_rf),
    .wren_rcf(wren_rcf),
    .datain_rcf(datain_rcf),
    .rcf_port(rcf_port),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk_fib = ~clk_fib;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream FMAC FIFO model: pop on rd, data valid next cycle, flags registered.
  logic [DW-1:0] dq0[$], dq1[$];
  logic [BW-1:0] iq0[$], iq1[$];
  logic [NP-1:0] stall = '0;

  always @(posedge clk_fib) begin : fifo_model
    int n0, n1, m0, m1;
    logic [DW-1:0] d;
    logic [BW-1:0] w;
    n0 = dq0.size(); n1 = dq1.size(); m0 = iq0.size(); m1 = iq1.size();
    if (fib_rx_mac_rd[0] && n0 > 0) begin d = dq0.pop_front(); pkt_data[DW-1:0] <= d; n0--; end
    if (fib_rx_mac_rd[1] && n1 > 0) begin d = dq1.pop_front(); pkt_data[2*DW-1:DW] <= d; n1--; end
    if (fib_rx_mac_ipcs_rd[0] && m0 > 0) begin w = iq0.pop_front(); ipcs_data[BW-1:0] <= w; m0--; end
    if (fib_rx_mac_ipcs_rd[1] && m1 > 0) begin w = iq1.pop_front(); ipcs_data[2*BW-1:BW] <= w; m1--; end
    data_empty <= {(n1 == 0) || stall[1], (n0 == 0) || stall[0]};
    ipcs_empty <= {(m1 == 0), (m0 == 0)};
  end

  // Output monitor, sampled on the falling edge.
  logic [DW-1:0] rf_log[$];
  logic [BW-1:0] rcf_word_log[$];
  int            rcf_port_log[$];
  int            rcf_idx_log[$];
  int            rcf_with_rf_log[$];
  int            rd_cyc0[$];
  int rd_cnt0 = 0, rd_cnt1 = 0, ipcs_cnt0 = 0, ipcs_cnt1 = 0;
  int busy_cyc = 0, proto_err = 0, cyc = 0;

  always @(negedge clk_fib) begin
    cyc++;
    if (wren_rf) rf_log.push_back(datain_rf);
    if (wren_rcf) begin
      rcf_word_log.push_back(datain_rcf);
      rcf_port_log.push_back(int'(rcf_port));
      rcf_idx_log.push_back(rf_log.size());
      rcf_with_rf_log.push_back(int'(wren_rf));
    end
    if (fib_rx_mac_rd[0]) begin rd_cnt0++; rd_cyc0.push_back(cyc); end
    if (fib_rx_mac_rd[1]) rd_cnt1++;
    if (fib_rx_mac_ipcs_rd[0]) ipcs_cnt0++;
    if (fib_rx_mac_ipcs_rd[1]) ipcs_cnt1++;
    if (busy) busy_cyc++;
    if (fib_rx_mac_rd == 2'b11 || fib_rx_mac_ipcs_rd == 2'b11 ||
        (fib_rx_mac_rd & data_empty) != '0 || (fib_rx_mac_ipcs_rd & ipcs_empty) != '0)
      proto_err++;
  end

  // Expected results, built as packets are pushed upstream.
  logic [DW-1:0] exp_rf[$];
  logic [BW-1:0] exp_rcf_word[$];
  int            exp_rcf_port[$];
  int            exp_rcf_idx[$];
  int exp_rd0 = 0, exp_rd1 = 0, exp_ipcs0 = 0, exp_ipcs1 = 0;
  int pkt_id = 1;

  function automatic logic [255:0] beat_word(input int port, input int id, input int beat);
    logic [255:0] w;
    w = {32{8'h5A}};
    w[255:248] = 8'(port);
    w[247:232] = 16'(id);
    w[231:216] = 16'(beat);
    return w;
  endfunction

  task automatic push_pkt(input int port, input int len, input int beats);
    logic [BW-1:0] w;
    logic [DW-1:0] d;
    w = {16'(len), 16'(pkt_id), 24'hC0DE00, 8'(port)};
    if (port == 0) begin iq0.push_back(w); exp_ipcs0++; exp_rd0 += beats; end
    else           begin iq1.push_back(w); exp_ipcs1++; exp_rd1 += beats; end
    for (int b = 0; b < beats; b++) begin
      d = beat_word(port, pkt_id, b);
      if (port == 0) dq0.push_back(d); else dq1.push_back(d);
      exp_rf.push_back(d);
    end
    if (len != 0) begin
      exp_rcf_word.push_back(w);
      exp_rcf_port.push_back(port);
      exp_rcf_idx.push_back(exp_rf.size());
    end
    pkt_id++;
  endtask

  task automatic clear_logs();
    rf_log.delete(); rcf_word_log.delete(); rcf_port_log.delete();
    rcf_idx_log.delete(); rcf_with_rf_log.delete(); rd_cyc0.delete();
    exp_rf.delete(); exp_rcf_word.delete(); exp_rcf_port.delete(); exp_rcf_idx.delete();
    rd_cnt0 = 0; rd_cnt1 = 0; ipcs_cnt0 = 0; ipcs_cnt1 = 0; busy_cyc = 0;
    exp_rd0 = 0; exp_rd1 = 0; exp_ipcs0 = 0; exp_ipcs1 = 0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int done;
    done = 0;
    for (int c = 0; c < max_cyc && done == 0; c++) begin
      @(negedge clk_fib); #1;
      if (iq0.size() == 0 && iq1.size() == 0 && dq0.size() == 0 && dq1.size() == 0 && !busy)
        done = 1;
    end
    check({tag, "_done"}, done, 1);
    @(posedge clk_fib); #1;
  endtask

  task automatic compare_and_clear(input string tag);
    check({tag, "_rd0"}, rd_cnt0, exp_rd0);
    check({tag, "_rd1"}, rd_cnt1, exp_rd1);
    check({tag, "_ipcs0"}, ipcs_cnt0, exp_ipcs0);
    check({tag, "_ipcs1"}, ipcs_cnt1, exp_ipcs1);
    check({tag, "_rf_cnt"}, rf_log.size(), exp_rf.size());
    for (int i = 0; i < exp_rf.size() && i < rf_log.size(); i++)
      check($sformatf("%s_rf_data%0d", tag, i), rf_log[i], exp_rf[i]);
    check({tag, "_rcf_cnt"}, rcf_word_log.size(), exp_rcf_word.size());
    for (int j = 0; j < exp_rcf_word.size() && j < rcf_word_log.size(); j++) begin
      check($sformatf("%s_rcf_word%0d", tag, j), rcf_word_log[j], exp_rcf_word[j]);
      check($sformatf("%s_rcf_port%0d", tag, j), rcf_port_log[j], exp_rcf_port[j]);
      check($sformatf("%s_rcf_at_beat%0d", tag, j), rcf_idx_log[j], exp_rcf_idx[j]);
      check($sformatf("%s_rcf_with_rf%0d", tag, j), rcf_with_rf_log[j], 1);
    end
    clear_logs();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"}, fib_rx_mac_rd, 0);
    check({tag, "_ipcs_rd"}, fib_rx_mac_ipcs_rd, 0);
    check({tag, "_wren_rf"}, wren_rf, 0);
    check({tag, "_datain_rf"}, datain_rf, 0);
    check({tag, "_wren_rcf"}, wren_rcf, 0);
    check({tag, "_datain_rcf"}, datain_rcf, 0);
    check({tag, "_rcf_port"}, rcf_port, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  typedef struct {
    int port;
    int len;
    int beats;   // (len + 31) / 32, hand-computed
    int drop;    // drop_cnt expected once this vector has completed
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int gap_a, gap_b;

    vecs[0] = '{port: 0, len: 64,   beats: 2,  drop: 0};
    vecs[1] = '{port: 1, len: 0,    beats: 0,  drop: 1};
    vecs[2] = '{port: 1, len: 33,   beats: 2,  drop: 1};
    vecs[3] = '{port: 0, len: 1,    beats: 1,  drop: 1};
    vecs[4] = '{port: 1, len: 32,   beats: 1,  drop: 1};
    vecs[5] = '{port: 0, len: 100,  beats: 4,  drop: 1};
    vecs[6] = '{port: 1, len: 0,    beats: 0,  drop: 2};
    vecs[7] = '{port: 1, len: 1024, beats: 32, drop: 2};

    #2 reset = 1'b1;
    repeat (3) @(posedge clk_fib);
    #1 check_zero("reset");
    reset = 1'b0;
    @(posedge clk_fib); #1;

    // Single packets; a zero-length vector is followed by a data packet on
    // the same port, since its own port is only eligible with data present.
    for (int v = 0; v < 8; v++) begin
      push_pkt(vecs[v].port, vecs[v].len, vecs[v].beats);
      if (vecs[v].len != 0) begin
        wait_idle($sformatf("vec%0d", v), vecs[v].beats + 60);
        check($sformatf("vec%0d_drop_cnt", v), drop_cnt, vecs[v].drop);
        compare_and_clear($sformatf("vec%0d", v));
      end
    end

    // Both ports loaded: last grant was port 1, so the order is 0,1,0,1,
    // which is the push order of the expected queues.
    push_pkt(0, 100, 4);
    push_pkt(1, 100, 4);
    push_pkt(0, 100, 4);
    push_pkt(1, 100, 4);
    wait_idle("rr", 150);
    compare_and_clear("rr");

    // Space threshold: blocked at 960, starts one cycle after 959.
    wrusedw_rf = 11'd960;
    push_pkt(0, 64, 2);
    repeat (10) @(negedge clk_fib);
    #1;
    check("space_busy_cycles", busy_cyc, 0);
    check("space_ipcs_blocked", ipcs_cnt0, 0);
    @(posedge clk_fib); #1;
    wrusedw_rf = 11'd959;
    @(posedge clk_fib);
    @(negedge clk_fib);
    check("space_start_busy", busy, 1);
    check("space_start_ipcs_rd", fib_rx_mac_ipcs_rd, 2'b01);
    wait_idle("space", 60);
    wrusedw_rf = '0;
    compare_and_clear("space");

    // Stall after the 2nd beat for 3 cycles.
    push_pkt(0, 160, 5);
    seen = 0;
    for (int c = 0; c < 60 && seen < 2; c++) begin
      @(negedge clk_fib);
      if (fib_rx_mac_rd[0]) seen++;
    end
    stall[0] = 1'b1;
    repeat (3) @(posedge clk_fib);
    #1 stall[0] = 1'b0;
    wait_idle("stall", 60);
    gap_a = (rd_cyc0.size() >= 2) ? (rd_cyc0[1] - rd_cyc0[0]) : -1;
    gap_b = (rd_cyc0.size() >= 3) ? (rd_cyc0[2] - rd_cyc0[1]) : -1;
    check("stall_rd_total", rd_cyc0.size(), 5);
    check("stall_gap_before", gap_a, 1);
    check("stall_gap_after", gap_b, 4);
    compare_and_clear("stall");

    // Reset in the middle of a 10-beat transfer.
    push_pkt(0, 320, 10);
    seen = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      @(negedge clk_fib);
      if (fib_rx_mac_rd[0]) seen++;
    end
    reset = 1'b1;
    #1 check_zero("rst_mid");
    @(posedge clk_fib); #1;
    dq0.delete(); dq1.delete(); iq0.delete(); iq1.delete();
    stall = '0;
    clear_logs();
    repeat (2) @(posedge clk_fib);
    #1 check("rst_hold_busy", busy, 0);
    reset = 1'b0;
    @(posedge clk_fib); #1;

    push_pkt(1, 64, 2);
    wait_idle("post_rst_a", 60);
    check("post_rst_a_drop_cnt", drop_cnt, 0);
    compare_and_clear("post_rst_a");
    push_pkt(0, 96, 3);
    wait_idle("post_rst_b", 60);
    compare_and_clear("post_rst_b");

    check("protocol_errors", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fib_rx_port_arb.md
Name: fib_rx_port_arb

Overview:
- Packet-granular round-robin scheduler that lets NUM_PORTS FMAC RX sources share one bridge data FIFO (rf) and one bridge byte-count FIFO (rcf).
- Sits between the FMAC RX FIFOs and the bridge FIFOs on clk_fib.
- Pops one packet at a time from the granted port: first its ipcs/byte-count word, then the packet's data beats. Writes the beats into rf and the count word into rcf.
- Checks bridge space before each packet and drops zero-length packets, counting each drop.

Parameters:
- NUM_PORTS, 2, number of FMAC RX sources (2..4)
- DATA_WIDTH, 256, data beat width (32 bytes per beat)
- BCNT_WIDTH, 64, ipcs word width; byte length in bits [63:48]
- DATA_PTR, 10, rf used-word count is DATA_PTR+1 bits
- SPACE_THRESH, 960, packet may start only if wrusedw_rf < SPACE_THRESH

Ports:
- clk_fib  in  1  fabric clock
- reset  in  1  asynchronous, active-high reset
- fib_rx_mac_data_empty  in  NUM_PORTS  per-port FMAC data FIFO empty
- fib_rx_mac_pkt_data  in  NUM_PORTS*DATA_WIDTH  per-port data; port i at [i*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after that port's rd
- fib_rx_mac_ipcs_empty  in  NUM_PORTS  per-port ipcs FIFO empty
- fib_rx_mac_ipcs_data  in  NUM_PORTS*BCNT_WIDTH  per-port ipcs word; valid 1 cycle after ipcs_rd
- fib_rx_mac_rd  out  NUM_PORTS  data pop strobes, one-hot or zero
- fib_rx_mac_ipcs_rd  out  NUM_PORTS  ipcs pop strobes, one-hot or zero
- wrusedw_rf  in  DATA_PTR+1  rf occupancy
- wren_rf  out  1  rf write enable
- datain_rf  out  DATA_WIDTH  rf write data
- wren_rcf  out  1  rcf write enable
- datain_rcf  out  BCNT_WIDTH  rcf write data (ipcs word, verbatim)
- rcf_port  out  2  port index of the packet whose count is being written; valid with wren_rcf
- busy  out  1  high in any state other than IDLE
- drop_cnt  out  16  zero-length packets dropped; saturating

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, last_grant=NUM_PORTS-1. Every output is 0: all strobes, datain_rf, datain_rcf, rcf_port, busy, drop_cnt.
- Eligible(i) = !ipcs_empty[i] && !data_empty[i].
- Start condition = any port eligible && wrusedw_rf < SPACE_THRESH.
- IDLE -> CNT_REQ when the start condition holds.
  - Grant goes to the first eligible port after last_grant, wrapping modulo NUM_PORTS.
  - The grant is latched, last_grant is updated, and ipcs_rd[grant] is pulsed for exactly 1 cycle.
- CNT_REQ -> CNT_LAT unconditionally; this is the ipcs read-latency cycle.
- CNT_LAT: latch the ipcs word and compute len = word[63:48] and beats = (len + 31) >> 5 (17-bit add, no overflow).
  - If len == 0: ipcs word consumed, no data read, no rf/rcf write, drop_cnt increments (saturates at 0xFFFF), go to IDLE.
  - Otherwise: remaining = beats, go to XFER.
- XFER:
  - Each cycle with remaining > 0 and !data_empty[grant]: assert rd[grant] and decrement remaining.
  - If data_empty[grant] is 1, rd stays 0 and the transfer stalls. There is no timeout.
  - When the last rd is issued, go to DRAIN.
- Write pipeline (every state): rd_d1 = |fib_rx_mac_rd delayed 1 cycle.
  - When rd_d1: datain_rf <= granted port's data and wren_rf <= 1; otherwise wren_rf <= 0 and datain_rf holds its value.
  - Latency from rd to wren_rf is 2 cycles.
- DRAIN: waits 2 cycles for the last beat to reach the write stage, then goes to IDLE.
  - wren_rcf=1 for exactly one cycle, coincident with the last wren_rf.
  - In that cycle datain_rcf = latched ipcs word and rcf_port = grant. Both hold their values afterwards.
- Space is checked only at packet start. A started packet always completes; SPACE_THRESH must leave at least max-packet beats of headroom.
- The grant is sticky for the whole packet; there is no preemption. Ports never interleave beats within rf.
- A port becoming eligible mid-packet waits until IDLE.
- The earliest back-to-back packet start is the cycle after DRAIN completes.
- A single eligible port is served repeatedly.
- Reset mid-packet aborts immediately. Partially popped FMAC data is not recovered; upstream is reset together with this block.

Test Plan:
- 2 ports, only port 0 holding a 64-byte packet, wrusedw_rf=0 -> ipcs_rd[0] one pulse, rd[0] for 2 cycles, 2 wren_rf. Second wren_rf is coincident with wren_rcf, rcf_port=0, datain_rcf=word.
- Both ports eligible continuously with 100-byte packets -> grant order 0,1,0,1. Each packet gives 4 beats, and beats are never interleaved.
- Port 1 ipcs word with len=0 -> no rd, no rf or rcf write, drop_cnt 0->1, back to IDLE. A following 33-byte packet gives 2 beats.
- Hold wrusedw_rf=960 with port 0 eligible -> stays IDLE, no strobes. Dropping to 959 -> packet starts within 1 cycle.
- 160-byte packet with data_empty[0] raised for 3 cycles after the 2nd beat -> rd gaps for 3 cycles. Exactly 5 wren_rf in total, each carrying the correct data in order.
- Assert reset in XFER of a 10-beat packet -> all outputs 0 asynchronously, state IDLE. Normal service resumes after deassertion.
